// File: rtl/fpu_pkg.sv
// Shared FPU definitions: per-format field widths, fflags bit positions,
// canonical special-value encodings and the operand class record.
// Used by the divider writeback stage and the other FPU units.
package fpu_pkg;

  // Bit positions inside the 5-bit fflags vector {NV,DZ,OF,UF,NX}.
  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

  // Canonical quiet NaN and +infinity for both supported formats.
  localparam logic [63:0] CANON_QNAN_64 = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] CANON_INF_64  = 64'h7FF0_0000_0000_0000;
  localparam logic [31:0] CANON_QNAN_32 = 32'h7FC0_0000;
  localparam logic [31:0] CANON_INF_32  = 32'h7F80_0000;

  // Exponent width for a given bus width: 32 -> single, otherwise double.
  function automatic int exp_width(input int bus_width);
    return (bus_width == 32) ? 8 : 11;
  endfunction

  // Mantissa (fraction) width: whatever is left after sign and exponent.
  function automatic int man_width(input int bus_width);
    return bus_width - 1 - exp_width(bus_width);
  endfunction

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
    logic finite;
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for one IEEE-754 value.
// Ports:
//   value : input  W-bit floating-point encoding
//   cls   : output {zero, inf, nan, snan, finite}
module fp_classify
  import fpu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] value,
  output fp_class_t    cls
);

  localparam int MAN_W = man_width(W);

  logic exp_all_ones;
  logic man_zero;

  assign exp_all_ones = &value[W-2:MAN_W];
  assign man_zero     = (value[MAN_W-1:0] == '0);

  always_comb begin
    cls        = '0;
    // Sign is ignored: both +0 and -0 count as zero.
    cls.zero   = (value[W-2:0] == '0);
    cls.inf    = exp_all_ones & man_zero;
    cls.nan    = exp_all_ones & ~man_zero;
    // Quiet bit is the mantissa MSB; a NaN with it clear is signalling.
    cls.snan   = exp_all_ones & ~man_zero & ~value[MAN_W-1];
    cls.finite = ~exp_all_ones;
  end

endmodule

// File: rtl/fpu_div_wb.sv
// Writeback stage behind the combinational FP divider. Each accepted
// quotient is stored with its destination register and the exception
// flags derived from the operands, then offered to the FP register file.
// A sticky fflags accumulator collects the flags of every popped entry.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous flush, empties the FIFO
//   in_valid/in_ready   : divider-side handshake
//   in_result/op1/op2   : quotient and its operands
//   in_rd               : destination register
//   out_valid/out_ready : register-file-side handshake
//   out_result/rd/fflags: head entry (zero when empty)
//   fflags_acc          : sticky OR of popped flags
//   clear_acc           : synchronous clear of fflags_acc
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. Valid never waits for ready; in_ready reflects only FIFO
// occupancy (a pop in a full cycle does not free space that same cycle);
// out_* hold steady while out_valid & !out_ready.
module fpu_div_wb
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH  = 64,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BUS_WIDTH-1:0]  in_result,
  input  logic [BUS_WIDTH-1:0]  in_op1,
  input  logic [BUS_WIDTH-1:0]  in_op2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BUS_WIDTH-1:0]  out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [4:0]            out_fflags,
  output logic [4:0]            fflags_acc,
  input  logic                  clear_acc
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  typedef struct packed {
    logic [BUS_WIDTH-1:0]  result;
    logic [REG_ADDR_W-1:0] rd;
    logic [4:0]            fflags;
  } entry_t;

  fp_class_t cls_a, cls_b, cls_r;

  fp_classify #(.W(BUS_WIDTH)) u_cls_op1 (.value(in_op1),    .cls(cls_a));
  fp_classify #(.W(BUS_WIDTH)) u_cls_op2 (.value(in_op2),    .cls(cls_b));
  fp_classify #(.W(BUS_WIDTH)) u_cls_res (.value(in_result), .cls(cls_r));

  logic unused_cls;
  assign unused_cls = ^{cls_a.nan, cls_b.nan, cls_r.nan, cls_r.snan, cls_r.finite};

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       acc_q, acc_d;

  logic   push;
  logic   pop;
  logic   [4:0] new_flags;
  entry_t head;

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  // A flush drops any same-cycle push; a same-cycle pop still completes.
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  assign head       = mem_q[rd_ptr_q];
  assign out_result = out_valid ? head.result : '0;
  assign out_rd     = out_valid ? head.rd     : '0;
  assign out_fflags = out_valid ? head.fflags : '0;
  assign fflags_acc = acc_q;

  always_comb begin
    new_flags           = '0;
    new_flags[FFLAG_NV] = (cls_a.zero & cls_b.zero) | (cls_a.inf & cls_b.inf)
                        | cls_a.snan | cls_b.snan;
    new_flags[FFLAG_DZ] = cls_b.zero & cls_a.finite & ~cls_a.zero;
    new_flags[FFLAG_OF] = cls_r.inf & cls_a.finite & ~cls_b.zero;
    new_flags[FFLAG_UF] = cls_r.zero & cls_a.finite & ~cls_a.zero
                        & cls_b.finite & ~cls_b.zero;
    new_flags[FFLAG_NX] = new_flags[FFLAG_OF] | new_flags[FFLAG_UF];
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{result: in_result, rd: in_rd, fflags: new_flags};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    acc_d = clear_acc ? 5'b0 : acc_q;
    if (pop) acc_d = acc_d | out_fflags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
    end
  end

  // Storage needs no reset: it is only observable through a non-zero count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
